// File: rtl/parking_ledger.sv
// Bay occupancy and parking-fee ledger fed by the entry/exit selector.
// Keeps a billing-unit timebase, per-bay entry stamps, the free-bay count and the last exit fee.
module parking_ledger #(
    parameter int SLOTS       = 8,
    parameter int MS_PER_UNIT = 1000,
    parameter int RATE        = 5,
    parameter int MIN_FEE     = 10
) (
    input  logic        ms,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic        activateSave,
    input  logic [2:0]  slot_id,
    output logic [7:0]  occupied,
    output logic [3:0]  free_count,
    output logic        full,
    output logic [15:0] fee,
    output logic        fee_valid,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_EXIT  = 3'd2,
        ST_POST  = 3'd3
    } sel_state_e;

    localparam int               SUB_W    = (MS_PER_UNIT > 1) ? $clog2(MS_PER_UNIT) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(MS_PER_UNIT - 1);
    localparam logic [15:0]      FEE_MIN  = 16'(MIN_FEE);

    logic [SUB_W-1:0] r_sub;
    logic [15:0]      r_now;
    logic [15:0]      r_stamp [SLOTS];
    logic [7:0]       r_occ;
    logic [3:0]       r_free;
    logic [15:0]      r_fee;
    logic             r_fee_valid;
    logic             r_err;

    logic [15:0] w_stamp_sel;
    logic [15:0] w_dur;
    logic [31:0] w_charge;
    logic [15:0] w_charge_sat;
    logic [15:0] w_fee_next;
    logic        w_slot_ok;
    logic        w_bay_busy;
    logic        w_is_entry;
    logic        w_is_exit;
    logic        w_entry_ok;
    logic        w_exit_ok;
    logic        w_reject;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ms) begin
        if (reset) begin
            r_sub <= '0;
            r_now <= 16'd0;
        end else if (r_sub == SUB_LAST) begin
            r_sub <= '0;
            r_now <= r_now + 16'd1;
        end else begin
            r_sub <= r_sub + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_stamp_sel = 16'd0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_id == 3'(i)) w_stamp_sel = r_stamp[i];
        end
    end

    assign w_slot_ok  = (int'(slot_id) < SLOTS);
    assign w_bay_busy = r_occ[slot_id];
    assign w_is_entry = activateSave && (state == ST_ENTRY);
    assign w_is_exit  = activateSave && (state == ST_EXIT);
    assign w_entry_ok = w_is_entry && w_slot_ok && !w_bay_busy;
    assign w_exit_ok  = w_is_exit && w_slot_ok && w_bay_busy;
    assign w_reject   = (w_is_entry && !w_entry_ok) || (w_is_exit && !w_exit_ok);

    // Modular difference: stays past 65535 units wrap and are undercharged.
    assign w_dur        = r_now - w_stamp_sel;
    assign w_charge     = 32'(w_dur) * 32'(RATE);
    assign w_charge_sat = (|w_charge[31:16]) ? 16'hFFFF : w_charge[15:0];
    assign w_fee_next   = (w_charge_sat < FEE_MIN) ? FEE_MIN : w_charge_sat;

    // NOTE: the stamp table is small and must read as zero after reset, so it is reset like any register.
    always_ff @(posedge ms) begin
        if (reset) begin
            r_occ       <= 8'd0;
            r_free      <= 4'(SLOTS);
            r_fee       <= 16'd0;
            r_fee_valid <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < SLOTS; i++) r_stamp[i] <= 16'd0;
        end else begin
            r_fee_valid <= w_exit_ok;
            r_err       <= w_reject;
            if (w_entry_ok) begin
                r_occ[slot_id] <= 1'b1;
                r_free         <= r_free - 4'd1;
            end
            if (w_exit_ok) begin
                r_occ[slot_id] <= 1'b0;
                r_free         <= r_free + 4'd1;
                r_fee          <= w_fee_next;
            end
            for (int i = 0; i < SLOTS; i++) begin
                if (w_entry_ok && (slot_id == 3'(i))) r_stamp[i] <= r_now;
            end
        end
    end

    assign occupied   = r_occ;
    assign free_count = r_free;
    assign full       = (r_free == 4'd0);
    assign fee        = r_fee;
    assign fee_valid  = r_fee_valid;
    assign err        = r_err;

endmodule
